// File: rtl/fix_point_mac_sequencer.sv
// Q8.8 dot-product sequencer: feeds one shared combinational multiplier one (x, w) pair per
// handshake, accumulates bias + sum(x*w) in a widened register, returns a saturated Q8.8 result.
module fix_point_mac_sequencer #(
  parameter int N_INPUTS = 4,
  parameter int CNT_W    = 8,
  parameter int ACC_W    = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bias,
  output logic        busy,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_w,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic [15:0] mul_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_sat
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  // ACC_W must leave headroom for N_INPUTS+1 full-scale Q8.8 terms, so the sum never wraps.
  localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI   = {{(ACC_W-16){1'b0}}, 16'h7FFF};
  localparam logic signed [ACC_W-1:0] SAT_LO   = {{(ACC_W-16){1'b1}}, 16'h8000};

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_nxt;
  logic [15:0]             sat_data;
  logic                    sat_flag;

  assign busy      = (state != IDLE);
  assign in_ready  = (state == MAC);
  assign out_valid = (state == DONE);

  // Operands only reach the shared multiplier while a dot product is consuming pairs.
  assign mul_a = in_ready ? in_x : 16'h0000;
  assign mul_b = in_ready ? in_w : 16'h0000;

  assign prod_ext = {{(ACC_W-16){mul_out[15]}}, mul_out};
  assign acc_nxt  = acc + prod_ext;

  always_comb begin
    sat_data = acc_nxt[15:0];
    sat_flag = 1'b0;
    if (acc_nxt > SAT_HI) begin
      sat_data = 16'h7FFF;
      sat_flag = 1'b1;
    end else if (acc_nxt < SAT_LO) begin
      sat_data = 16'h8000;
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      out_data <= 16'h0000;
      out_sat  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= {{(ACC_W-16){bias[15]}}, bias};
            cnt   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          if (in_valid) begin
            acc <= acc_nxt;
            cnt <= cnt + CNT_W'(1);
            // Result is frozen on the last pair so it stays stable for the whole DONE hold.
            if (cnt == LAST_CNT) begin
              out_data <= sat_data;
              out_sat  <= sat_flag;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fix_point_mac_sequencer.sv
// Directed bench for fix_point_mac_sequencer with a behavioural Q8.8 multiplier on the side port.
module tb_fix_point_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bias;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_w;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [15:0] mul_out;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fix_point_mac_sequencer #(.N_INPUTS(4), .CNT_W(8), .ACC_W(24)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
    .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  // Shared multiplier: (A*B)>>>8 truncated to 16 bits.
  logic signed [31:0] prod;
  always_comb begin
    prod    = $signed(mul_a) * $signed(mul_b);
    mul_out = prod[23:8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0]      bias;
    logic [3:0][15:0] x;
    logic [3:0][15:0] w;
    logic [15:0]      exp_data;
    logic             exp_sat;
  } vec_t;

  vec_t vecs[9];

  // Runs one dot product; called and returns at posedge+1.
  task automatic run_dot(input logic [15:0] b, input logic [3:0][15:0] xs, input logic [3:0][15:0] ws,
                         input bit gap, input int hold, input bit start_mid,
                         output logic [15:0] data, output logic sat, output int pairs, output int lat);
    int  idx   = 0;
    int  edges = 0;
    bit  acc;
    bit  mul_checked = 0;
    start = 1'b1;
    bias  = b;
    @(posedge clk); #1;
    start = 1'b0;
    while (!out_valid && edges < 40) begin
      start = start_mid && (edges == 1);
      if ((gap && (edges % 2 == 1)) || idx >= 4) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_x     = xs[idx];
        in_w     = ws[idx];
      end
      #1;
      if (in_valid && !mul_checked) begin
        chk("mul_a passthrough in MAC", {16'h0, mul_a}, {16'h0, in_x});
        chk("mul_b passthrough in MAC", {16'h0, mul_b}, {16'h0, in_w});
        mul_checked = 1;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      edges++;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (!out_valid) chk("out_valid timeout", 32'd0, 32'd1);
    data  = out_data;
    sat   = out_sat;
    pairs = idx;
    lat   = edges + 2;
    in_x  = 16'h1234;
    in_w  = 16'h5678;
    for (int h = 0; h < hold; h++) begin
      start = start_mid;
      @(posedge clk); #1;
      chk("out_valid held", {31'h0, out_valid}, 32'd1);
      chk("out_data stable", {16'h0, out_data}, {16'h0, data});
      chk("in_ready low in DONE", {31'h0, in_ready}, 32'd0);
      chk("mul_a/b zero in DONE", {mul_a, mul_b}, 32'd0);
    end
    out_ready = 1'b1;
    start     = start_mid;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    chk("out_valid drops after handshake", {31'h0, out_valid}, 32'd0);
    chk("busy low after handshake", {31'h0, busy}, 32'd0);
  endtask

  logic [15:0] r_data;
  logic        r_sat;
  int          r_pairs;
  int          r_lat;

  initial begin
    // bias, x[3:0], w[3:0] (packed, index 0 rightmost), expected data, expected sat
    vecs[0] = '{16'h0000, {16'h0100, 16'h0100, 16'h0100, 16'h0100}, {16'h0100, 16'h0100, 16'h0100, 16'h0100}, 16'h0400, 1'b0};
    vecs[1] = '{16'h0080, {16'h0300, 16'h0300, 16'h0300, 16'h0300}, {16'hFE00, 16'hFE00, 16'hFE00, 16'hFE00}, 16'hE880, 1'b0};
    vecs[2] = '{16'h0000, {16'h4000, 16'h4000, 16'h4000, 16'h4000}, {16'h0100, 16'h0100, 16'h0100, 16'h0100}, 16'h7FFF, 1'b1};
    vecs[3] = '{16'h0000, {16'h4000, 16'h4000, 16'h4000, 16'h4000}, {16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00}, 16'h8000, 1'b1};
    // -1 + 3.0 - 2.0 + 1/256 + 0
    vecs[4] = '{16'hFF00, {16'h7FFF, 16'h0010, 16'hFF80, 16'h0180}, {16'h0000, 16'h0010, 16'h0400, 16'h0200}, 16'h0001, 1'b0};
    // (-1/256 * 1/256)>>>8 floors to -1 LSB each
    vecs[5] = '{16'h0000, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, {16'h0001, 16'h0001, 16'h0001, 16'h0001}, 16'hFFFC, 1'b0};
    vecs[6] = '{16'h7FFF, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h7FFF, 1'b0};
    vecs[7] = '{16'h8000, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h8000, 1'b0};
    vecs[8] = '{16'h7FFF, {16'h0000, 16'h0000, 16'h0000, 16'h0001}, {16'h0000, 16'h0000, 16'h0000, 16'h0100}, 16'h7FFF, 1'b1};

    rst = 1'b1; start = 1'b0; bias = 16'h0; in_valid = 1'b1; in_x = 16'h1111; in_w = 16'h2222; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'h0, busy}, 32'd0);
    chk("reset in_ready", {31'h0, in_ready}, 32'd0);
    chk("reset out_valid", {31'h0, out_valid}, 32'd0);
    chk("reset out_data/out_sat", {15'h0, out_sat, out_data}, 32'd0);
    chk("reset mul_a/mul_b", {mul_a, mul_b}, 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle busy", {31'h0, busy}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_dot(vecs[i].bias, vecs[i].x, vecs[i].w, 1'b0, 0, 1'b0, r_data, r_sat, r_pairs, r_lat);
      chk($sformatf("vec%0d out_data", i), {16'h0, r_data}, {16'h0, vecs[i].exp_data});
      chk($sformatf("vec%0d out_sat", i), {31'h0, r_sat}, {31'h0, vecs[i].exp_sat});
      chk($sformatf("vec%0d pairs", i), r_pairs, 4);
      chk($sformatf("vec%0d latency", i), r_lat, 6);
    end

    // Bubbly input stream and a stalled consumer.
    run_dot(vecs[0].bias, vecs[0].x, vecs[0].w, 1'b1, 3, 1'b0, r_data, r_sat, r_pairs, r_lat);
    chk("gap out_data", {16'h0, r_data}, 32'h0400);
    chk("gap out_sat", {31'h0, r_sat}, 32'd0);
    chk("gap pairs", r_pairs, 4);

    // Abort after two accepted pairs.
    start = 1'b1; bias = 16'h0100;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_x = 16'h0100; in_w = 16'h0100;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", {31'h0, busy}, 32'd0);
    chk("abort out_valid", {31'h0, out_valid}, 32'd0);
    chk("abort in_ready", {31'h0, in_ready}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort no late out_valid", {31'h0, out_valid | busy}, 32'd0);
    run_dot(vecs[0].bias, vecs[0].x, vecs[0].w, 1'b0, 0, 1'b0, r_data, r_sat, r_pairs, r_lat);
    chk("post-abort out_data", {16'h0, r_data}, 32'h0400);
    chk("post-abort latency", r_lat, 6);

    // start pulsed in MAC, DONE and the handoff cycle must all be ignored.
    run_dot(vecs[0].bias, vecs[0].x, vecs[0].w, 1'b0, 2, 1'b1, r_data, r_sat, r_pairs, r_lat);
    chk("stray start out_data", {16'h0, r_data}, 32'h0400);
    chk("stray start pairs", r_pairs, 4);
    chk("stray start latency", r_lat, 6);
    @(posedge clk); #1;
    chk("stray start idle busy", {31'h0, busy}, 32'd0);
    chk("mul_a/b zero in IDLE", {mul_a, mul_b}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
